mem_responder: RTL

// - Word-addressed RAM responder on the memory side of the CPU memory strobes.
// - Services in_mem_read/in_mem_write from the control unit, using the MAR address and MDR write data.
// - Returns read data for the MDR input mux and pulses out_ready when each access completes.
// - Inserts a fixed, programmable number of wait states so slower memory can be modelled.

---
 rtl/mem_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Word-addressed RAM responder with programmable wait states; answers the CPU memory strobes.
// Optional MEM_BOUNDS_CHECK_EN flags and suppresses accesses with upper address bits set.
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  in_reset,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [31:0]           in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic                  out_ready,
  output logic                  out_busy,
  output logic                  out_fault
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t                  state;
  logic [3:0]              cnt;
  logic                    op_write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    oor_q;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  logic                    accept;
  logic                    commit;
  logic                    req_oor;
  logic                    c_write;
  logic                    c_oor;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic [DATA_WIDTH-1:0]   c_wdata;

`ifdef MEM_BOUNDS_CHECK_EN
  assign req_oor = |in_addr[31:ADDR_WIDTH];
`else
  // Upper address bits alias onto the array when bounds checking is off.
  logic unused_upper;
  assign req_oor      = 1'b0;
  assign unused_upper = ^in_addr[31:ADDR_WIDTH];
`endif

  assign accept = (state == IDLE) && (in_mem_read || in_mem_write);

  // With zero wait states the commit edge is the accept edge, so the live inputs are used.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    c_write = op_write_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_oor   = oor_q;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        c_write = in_mem_write;
        c_addr  = in_addr[ADDR_WIDTH-1:0];
        c_wdata = in_wdata;
        c_oor   = req_oor;
        commit  = accept && (WAIT_STATES == 0);
      end
      WAIT:    commit = (cnt == 4'd0);
      default: commit = 1'b0;
    endcase
  end

  // NOTE: the array has no reset; contents survive in_reset, and a reset-free block lets it map to RAM.
  always_ff @(posedge clk) begin
    if (commit && c_write && !c_oor && !in_reset)
      mem[c_addr] <= c_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge in_reset) begin
    if (in_reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
      out_rdata  <= '0;
      out_ready  <= 1'b0;
      out_busy   <= 1'b0;
      out_fault  <= 1'b0;
    end else begin
      out_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_write_q <= in_mem_write;
            addr_q     <= in_addr[ADDR_WIDTH-1:0];
            wdata_q    <= in_wdata;
            oor_q      <= req_oor;
            out_busy   <= 1'b1;
            out_fault  <= 1'b0;
            cnt        <= CNT_LOAD;
            state      <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          state    <= IDLE;
          out_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // Placed after the case so a same-edge commit overrides the fault clear on accept.
      if (commit) begin
        out_ready <= 1'b1;
        out_fault <= c_oor;
        if (!c_write) out_rdata <= c_oor ? '0 : mem[c_addr];
      end
    end
  end

endmodule
